uart_rx_packer: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_packer_if.sv | 15 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_packer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_packer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART receive/pack path.
//   rx_state_e  : receiver FSM states
//   calc_div    : clocks per oversample tick (integer-truncated)
//   calc_words  : output words per packed frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic int calc_div(int clk_hz, int baud, int oversample);
    return clk_hz / (baud * oversample);
  endfunction

  function automatic int calc_words(int bytes_per_frame, int word_w);
    return (bytes_per_frame * 8) / word_w;
  endfunction

endpackage

// File: rtl/uart_rx_packer_if.sv
// Memory write port driven by the packer.
//   wr_en   : write strobe
//   wr_addr : word address, valid while wr_en is high
//   wr_data : word data, held when wr_en is low
interface uart_rx_packer_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
//   clk, rst_n : clock, async active-low reset
//   tick       : one-cycle pulse
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_packer.sv
// Oversampled UART receiver with start-glitch rejection and stop-bit check,
// packing BYTES_PER_FRAME bytes (first byte most significant) into a frame
// that is written out as WORD_W-bit words to an auto-incrementing address.
//   clk, rst_n : clock, async active-low reset
//   uart_rx    : asynchronous serial line, idle high
//   clr_addr   : sync pulse: address to 0, drop partial frame, abort emission
//   rx_byte    : last good byte;  rx_valid: one-cycle pulse on update
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   wr         : memory write port (wr_en / wr_addr / wr_data)
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int BAUD            = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int BYTES_PER_FRAME = 3,
  parameter int WORD_W          = 12,
  parameter int ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              clr_addr,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              frame_err,
  uart_rx_packer_if.master  wr
);
  localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int WORDS  = calc_words(BYTES_PER_FRAME, WORD_W);
  localparam int TOTAL  = BYTES_PER_FRAME * 8;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(BYTES_PER_FRAME + 1);
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [OS_W-1:0] HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] LAST = OS_W'(OVERSAMPLE - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_packer: clock too slow for BAUD*OVERSAMPLE");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
    $error("uart_rx_packer: OVERSAMPLE must be even and >= 4");
  end
  if ((TOTAL % WORD_W) != 0) begin : g_bad_word
    $error("uart_rx_packer: BYTES_PER_FRAME*8 must be a multiple of WORD_W");
  end
  if (WORDS >= DIV * OVERSAMPLE * 10) begin : g_bad_emit
    $error("uart_rx_packer: emission cannot finish within one byte time");
  end

  // Word k of a frame, most significant word first.
  function automatic logic [WORD_W-1:0] word_at(logic [TOTAL-1:0] f, int k);
    return WORD_W'(f >> ((WORDS - 1 - k) * WORD_W));
  endfunction

  logic tick;
  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE))
    u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  // ---------------- receiver ----------------
  logic [1:0]      sync_q, sync_d;
  rx_state_e       state_q, state_d;
  logic [OS_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic            rx_s, stop_sample;

  assign sync_d = {sync_q[0], uart_rx};
  assign rx_s   = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: if (tick && !rx_s) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: if (tick) begin
        if (cnt_q == HALF) begin
          // Line back high at mid start bit: a glitch, not a start.
          state_d = rx_s ? IDLE : DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: if (tick) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      STOP: if (tick) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end else cnt_d = cnt_q + 1'b1;
      end
      // Evaluated every clock so a held-low break cannot re-trigger a start.
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    stop_sample = (state_q == STOP) && tick && (cnt_q == LAST);
    rx_valid_d  = stop_sample && rx_s;
    frame_err_d = stop_sample && !rx_s;
    rx_byte_d   = rx_valid_d ? shreg_q : rx_byte_q;
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  // ---------------- packer / emitter ----------------
  logic [TOTAL-1:0]   pack_q, pack_d, ebuf_q, ebuf_d, pack_new;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [TOTAL+7:0]   pack_shift;

  always_comb begin
    pack_shift = {pack_q, rx_byte_q};
    pack_new   = pack_shift[TOTAL-1:0];
    pack_d     = pack_q;
    bcnt_d     = bcnt_q;
    ebuf_d     = ebuf_q;
    widx_d     = widx_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    // Registered strobe: address advances after each write.
    if (wen_q) begin
      waddr_d = waddr_q + 1'b1;
      if (widx_q != WIDX_W'(WORDS - 1)) begin
        wen_d   = 1'b1;
        widx_d  = widx_q + 1'b1;
        wdata_d = word_at(ebuf_q, int'(widx_q) + 1);
      end
    end

    if (frame_err_q) bcnt_d = '0;

    if (rx_valid_q) begin
      pack_d = pack_new;
      if (bcnt_q == BCNT_W'(BYTES_PER_FRAME - 1)) begin
        ebuf_d  = pack_new;
        bcnt_d  = '0;
        wen_d   = 1'b1;
        widx_d  = '0;
        wdata_d = word_at(pack_new, 0);
      end else bcnt_d = bcnt_q + 1'b1;
    end

    if (clr_addr) begin
      waddr_d = '0;
      bcnt_d  = '0;
      wen_d   = 1'b0;
      widx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= '0;
      ebuf_q  <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      pack_q  <= pack_d;
      ebuf_q  <= ebuf_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr.wr_en   = wen_q;
  assign wr.wr_addr = waddr_q;
  assign wr.wr_data = wdata_q;
endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: serial stimulus with a byte/frame
// reference model; a monitor compares every rx_valid, frame_err and write.
module tb_uart_rx_packer;
  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 8;
  localparam int BPF      = 3;
  localparam int WORD_W   = 12;
  localparam int ADDR_W   = 2;
  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int TICK_CLKS = CLK_HZ / (BAUD * OS);
  localparam int WORDS    = BPF * 8 / WORD_W;

  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, clr_addr = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  uart_rx_packer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) wr ();

  uart_rx_packer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                   .BYTES_PER_FRAME(BPF), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .clr_addr(clr_addr),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err), .wr(wr));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] d;
  } wr_t;

  logic [7:0] rx_q[$];
  wr_t        wr_q[$];
  logic [7:0] frame[$];
  int         exp_err = 0;
  int         m_addr = 0;
  int         n_chk = 0, n_pass = 0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: bytes join a frame; a full frame becomes WORDS writes.
  task automatic model_byte(logic [7:0] b, logic good);
    logic [BPF*8-1:0] f;
    if (!good) begin
      exp_err++;
      frame.delete();
      return;
    end
    rx_q.push_back(b);
    frame.push_back(b);
    if (frame.size() == BPF) begin
      f = '0;
      foreach (frame[i]) f = {f[BPF*8-9:0], frame[i]};
      frame.delete();
      for (int k = 0; k < WORDS; k++) begin
        wr_q.push_back(wr_t'{a: ADDR_W'(m_addr),
                             d: WORD_W'(f >> ((WORDS - 1 - k) * WORD_W))});
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b, logic stop);
    model_byte(b, stop);
    @(negedge clk);
    uart_rx = 1'b0; idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; idle(BIT_CLKS);
    end
    uart_rx = stop; idle(BIT_CLKS);
    uart_rx = 1'b1; idle(BIT_CLKS);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_addr = 1'b1;
    frame.delete();
    m_addr = 0;
    @(negedge clk);
    clr_addr = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        check("rx_pending", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) check("rx_byte", rx_byte, rx_q.pop_front());
      end
      if (frame_err) begin
        check("frame_err_pending", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
      if (wr.wr_en) begin
        check("wr_pending", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", wr.wr_addr, e.a);
          check("wr_data", wr.wr_data, e.d);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    idle(3);
    check("reset_outputs", {rx_byte, rx_valid, frame_err, wr.wr_en, wr.wr_addr, wr.wr_data}, 0);
    rst_n = 1'b1;
    idle(20);

    // Single byte, no write
    send_byte(8'hA5, 1'b1);
    idle(20);
    pulse_clr();

    // One full frame
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    idle(20);
    check("addr_after_frame", wr.wr_addr, 2);

    // Start glitch of three tick periods
    @(negedge clk);
    uart_rx = 1'b0; idle(3 * TICK_CLKS);
    uart_rx = 1'b1; idle(4 * BIT_CLKS);
    send_byte(8'h3C, 1'b1);
    pulse_clr();

    // Framing error realigns the frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(20);

    // Three random frames: address wraps
    pulse_clr();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    // clr mid-frame: partial frame dropped, next write at 0
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    pulse_clr();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    // Random stream with occasional bad stop bits
    for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
    idle(20);

    // Reset in the middle of a byte
    b = 8'h5A;
    @(negedge clk);
    uart_rx = 1'b0; idle(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i]; idle(BIT_CLKS);
    end
    #2 rst_n = 1'b0;
    #1 check("reset_mid_byte", {rx_byte, rx_valid, frame_err, wr.wr_en, wr.wr_addr, wr.wr_data}, 0);
    frame.delete();
    m_addr = 0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle(4);
    rst_n = 1'b1;
    idle(20);
    send_byte(8'h7E, 1'b1);
    idle(40);

    check("rx_queue_drained", rx_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    check("frame_err_drained", exp_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
